// File: rtl/modinv_loop_sequencer.sv
// Loop sequencer for the modular invertor: init, almost-inverse and reduction phases.
// Define MODINV_SEQ_EARLY_EXIT_EN for the variable-time build (early phase exits).
module modinv_loop_sequencer #(
    parameter int OPERAND_NUM_BITS = 256,
    parameter int K_NUM_BITS       = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    output logic                  rdy,
    output logic                  no_inv,
    output logic                  init_ena,
    input  logic                  init_rdy,
    output logic                  step_ena,
    input  logic                  step_rdy,
    input  logic                  step_v_is_one,
    output logic                  step_hold,
    output logic                  prep_ena,
    input  logic                  prep_rdy,
    input  logic                  s_lsb,
    output logic                  upd_ena,
    input  logic                  upd_rdy,
    output logic                  s_is_odd,
    output logic                  k_is_nul,
    output logic [K_NUM_BITS-1:0] k_cnt
);

    localparam int ITERS = 2 * OPERAND_NUM_BITS;
    localparam int IT_W  = $clog2(ITERS + 1);
    localparam logic [IT_W-1:0]       IT_LAST = IT_W'(ITERS - 1);
    localparam logic [K_NUM_BITS-1:0] K_ZERO  = {K_NUM_BITS{1'b0}};
    localparam logic [K_NUM_BITS-1:0] K_MAX   = {K_NUM_BITS{1'b1}};

    typedef enum logic [3:0] {
        S_IDLE, S_INIT_GO, S_INIT_WAIT, S_STEP_GO, S_STEP_WAIT,
        S_PREP_GO, S_PREP_WAIT, S_UPD_GO, S_UPD_WAIT
    } state_t;

    state_t                  state_q;
    logic                    rdy_q, no_inv_q, step_hold_q, s_is_odd_q, wait_first_q;
    logic                    init_ena_q, step_ena_q, prep_ena_q, upd_ena_q;
    logic [K_NUM_BITS-1:0]   k_q;
    logic [IT_W-1:0]         it_q;

    logic                    helper_rdy_s, done_s, it_last_s, step_exit_s, upd_exit_s;
    logic [K_NUM_BITS-1:0]   k_inc_d, k_dec_d;
    logic [IT_W-1:0]         it_inc_d;

    // Helper-ready selection, saturating k arithmetic and loop exit conditions.
    always_comb begin
        helper_rdy_s = 1'b0;
        case (state_q)
            S_INIT_WAIT: helper_rdy_s = init_rdy;
            S_STEP_WAIT: helper_rdy_s = step_rdy;
            S_PREP_WAIT: helper_rdy_s = prep_rdy;
            S_UPD_WAIT:  helper_rdy_s = upd_rdy;
            default:     helper_rdy_s = 1'b0;
        endcase
        if (k_q != K_MAX) begin
            k_inc_d = k_q + K_NUM_BITS'(1);
        end else begin
            k_inc_d = k_q;
        end
        if (k_q != K_ZERO) begin
            k_dec_d = k_q - K_NUM_BITS'(1);
        end else begin
            k_dec_d = k_q;
        end
        it_inc_d  = it_q + IT_W'(1);
        it_last_s = (it_q == IT_LAST);
        // The helper still shows the previous rdy on the first wait cycle.
        done_s    = helper_rdy_s & ~wait_first_q;
`ifdef MODINV_SEQ_EARLY_EXIT_EN
        step_exit_s = it_last_s | step_v_is_one;
        upd_exit_s  = it_last_s | (k_dec_d == K_ZERO);
`else
        step_exit_s = it_last_s;
        upd_exit_s  = it_last_s;
`endif
    end

    // Sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rdy_q        <= 1'b1;
            no_inv_q     <= 1'b0;
            step_hold_q  <= 1'b0;
            s_is_odd_q   <= 1'b0;
            wait_first_q <= 1'b0;
            init_ena_q   <= 1'b0;
            step_ena_q   <= 1'b0;
            prep_ena_q   <= 1'b0;
            upd_ena_q    <= 1'b0;
            k_q          <= K_ZERO;
            it_q         <= {IT_W{1'b0}};
        end else begin
            init_ena_q   <= 1'b0;
            step_ena_q   <= 1'b0;
            prep_ena_q   <= 1'b0;
            upd_ena_q    <= 1'b0;
            wait_first_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ena) begin
                        k_q         <= K_ZERO;
                        it_q        <= {IT_W{1'b0}};
                        step_hold_q <= 1'b0;
                        no_inv_q    <= 1'b0;
                        rdy_q       <= 1'b0;
                        init_ena_q  <= 1'b1;
                        state_q     <= S_INIT_GO;
                    end
                end
                S_INIT_GO: begin
                    wait_first_q <= 1'b1;
                    state_q      <= S_INIT_WAIT;
                end
                S_INIT_WAIT: begin
                    if (done_s) begin
                        step_ena_q <= 1'b1;
                        state_q    <= S_STEP_GO;
                    end
                end
                S_STEP_GO: begin
                    wait_first_q <= 1'b1;
                    state_q      <= S_STEP_WAIT;
                end
                S_STEP_WAIT: begin
                    if (done_s) begin
                        if (step_v_is_one) begin
                            step_hold_q <= 1'b1;
                        end else if (!step_hold_q) begin
                            k_q <= k_inc_d;
                        end
                        if (step_exit_s) begin
                            it_q       <= {IT_W{1'b0}};
                            no_inv_q   <= ~(step_hold_q | step_v_is_one);
                            prep_ena_q <= 1'b1;
                            state_q    <= S_PREP_GO;
                        end else begin
                            it_q       <= it_inc_d;
                            step_ena_q <= 1'b1;
                            state_q    <= S_STEP_GO;
                        end
                    end
                end
                S_PREP_GO: begin
                    wait_first_q <= 1'b1;
                    state_q      <= S_PREP_WAIT;
                end
                S_PREP_WAIT: begin
                    if (done_s) begin
                        s_is_odd_q <= s_lsb;
                        upd_ena_q  <= 1'b1;
                        state_q    <= S_UPD_GO;
                    end
                end
                S_UPD_GO: begin
                    wait_first_q <= 1'b1;
                    state_q      <= S_UPD_WAIT;
                end
                S_UPD_WAIT: begin
                    if (done_s) begin
                        k_q <= k_dec_d;
                        if (upd_exit_s) begin
                            it_q    <= {IT_W{1'b0}};
                            rdy_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            it_q       <= it_inc_d;
                            prep_ena_q <= 1'b1;
                            state_q    <= S_PREP_GO;
                        end
                    end
                end
                default: begin
                    rdy_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rdy       = rdy_q;
    assign no_inv    = no_inv_q;
    assign init_ena  = init_ena_q;
    assign step_ena  = step_ena_q;
    assign prep_ena  = prep_ena_q;
    assign upd_ena   = upd_ena_q;
    assign step_hold = step_hold_q;
    assign s_is_odd  = s_is_odd_q;
    assign k_cnt     = k_q;
    assign k_is_nul  = (k_q == K_ZERO);

endmodule
